// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writeback requesters.
// Optional burst lock; define RF_WR_X0_DROP_EN to suppress writes to x0.
module rf_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_lock,
  input  logic [5*NUM_REQ-1:0]    req_addr,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    WE,
  output logic [4:0]              A3,
  output logic [31:0]             WD3,
  output logic                    locked,
  output logic [1:0]              lock_owner
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {StArb, StLocked} state_e;

  state_e          state_q, state_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [1:0]      owner_q, owner_d;
  logic [CntW-1:0] burst_cnt_q, burst_cnt_d;

  logic [NUM_REQ-1:0] grant;
  logic               found;
  logic               xfer;
  logic [1:0]         gnt_idx;
  logic [4:0]         gnt_addr;
  logic [31:0]        gnt_data;
  logic               gnt_lock;
  logic               wr_en;

  function automatic logic [1:0] wrap_inc(input logic [1:0] v);
    return ((32'(v) + 32'd1) >= NUM_REQ) ? 2'd0 : v + 2'd1;
  endfunction

  // Two passes give the rotated priority: indices >= rr_ptr first, then the wrapped ones.
  always_comb begin
    grant = '0;
    found = 1'b0;
    if (state_q == StLocked) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (owner_q == 2'(i)) grant[i] = req_valid[i];
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] && (2'(i) >= rr_ptr_q)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] && (2'(i) < rr_ptr_q)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    if (!rst) grant = '0;
  end

  assign req_ready = grant;

  always_comb begin
    xfer     = 1'b0;
    gnt_idx  = '0;
    gnt_addr = '0;
    gnt_data = '0;
    gnt_lock = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        xfer     = 1'b1;
        gnt_idx  = 2'(i);
        gnt_addr = req_addr[5*i +: 5];
        gnt_data = req_data[32*i +: 32];
        gnt_lock = req_lock[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      StArb: begin
        if (xfer) begin
          rr_ptr_d = wrap_inc(gnt_idx);
          if (gnt_lock && (MAX_BURST > 1)) begin
            state_d     = StLocked;
            owner_d     = gnt_idx;
            burst_cnt_d = CntW'(1);
          end
        end
      end
      StLocked: begin
        // Owner idle, lock dropped, or burst exhausted all hand the port back.
        if (!xfer || !gnt_lock || ((32'(burst_cnt_q) + 32'd1) == MAX_BURST)) begin
          state_d     = StArb;
          rr_ptr_d    = wrap_inc(owner_q);
          owner_d     = '0;
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = burst_cnt_q + CntW'(1);
        end
      end
      default: state_d = StArb;
    endcase
  end

`ifdef RF_WR_X0_DROP_EN
  assign wr_en = xfer && (gnt_addr != 5'd0);
`else
  assign wr_en = xfer;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StArb;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      WE          <= 1'b0;
      A3          <= '0;
      WD3         <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      WE          <= wr_en;
      if (wr_en) begin
        A3  <= gnt_addr;
        WD3 <= gnt_data;
      end
    end
  end

  assign locked     = (state_q == StLocked);
  assign lock_owner = owner_q;

endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Shares the register file's single write port (WE/A3/WD3) among NUM_REQ independent writeback requesters, such as core writeback, a multi-cycle load unit and a debug/program loader.
- Uses round-robin arbitration with valid/ready handshakes.
- Supports an optional burst lock so one requester can write a bounded run of registers back-to-back.
- Sits between the writeback sources and Reg_File; its registered outputs drive Reg_File's WE, A3 and WD3 directly.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- MAX_BURST, 8, maximum consecutive grants to one requester while locked; must be >= 1.

Ports:
- clk  input  1  write clock, shared with Reg_File.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- req_valid  input  NUM_REQ  per-requester write request.
- req_lock  input  NUM_REQ  per-requester request to hold the grant after this transfer.
- req_addr  input  5*NUM_REQ  destination register; requester i uses bits [5i+4:5i].
- req_data  input  32*NUM_REQ  write data; requester i uses bits [32i+31:32i].
- req_ready  output  NUM_REQ  one-hot grant; at most one bit set.
- WE  output  1  registered write enable to Reg_File.
- A3  output  5  registered write address.
- WD3  output  32  registered write data.
- locked  output  1  high while in LOCKED state.
- lock_owner  output  2  index of the lock holder; 0 when not locked.

Behaviour:
- Handshake:
  - A transfer occurs on requester i at a rising clk edge when req_valid[i] and req_ready[i] are both 1.
  - A requester must hold req_addr, req_data and req_lock stable while valid and not ready.
  - req_ready is combinational from req_valid, state and rr_ptr. It never depends on req_addr or req_data.
- Output stage:
  - The output stage never stalls, so there is at most one transfer per cycle.
  - A transfer at edge k gives WE=1, A3=addr and WD3=data throughout cycle k+1. Reg_File commits the write at edge k+1, so the latency from request to commit is 2 edges.
  - In a cycle with no transfer, WE=0 at the next edge and A3/WD3 hold their previous values.
- State ARB:
  - The search starts at rr_ptr and wraps modulo NUM_REQ. The first requester found with valid=1 gets ready=1.
  - On a transfer from requester i, rr_ptr becomes (i+1) mod NUM_REQ.
  - If req_lock[i]=1 at that transfer and MAX_BURST > 1, the next state is LOCKED with owner=i and burst_cnt=1. Otherwise the state stays ARB.
- State LOCKED:
  - Only the owner can be granted: req_ready[owner]=req_valid[owner], and all other ready bits are 0.
  - Each owner transfer increments burst_cnt.
  - Exit to ARB at the edge where any of the following happens:
    - the owner transfers with req_lock=0;
    - the owner's transfer makes burst_cnt == MAX_BURST (forced release);
    - the owner's req_valid=0, in which case no grant occurs that cycle.
  - On exit, rr_ptr = (owner+1) mod NUM_REQ and burst_cnt = 0.
- Counter widths:
  - burst_cnt is $clog2(MAX_BURST+1) bits wide and never exceeds MAX_BURST.
  - rr_ptr is 2 bits wide; the wrap is explicit, not a power-of-two rollover.
- Reset (rst=0, asynchronous): WE=0, A3=0, WD3=0, state=ARB, rr_ptr=0, burst_cnt=0, locked=0, lock_owner=0, req_ready=0.
  - Reset asserted mid-burst discards the lock and any pending output write immediately; WE drops without waiting for clk.
  - After reset deasserts, arbitration restarts from requester 0.
- Simultaneous requests: exactly one grant per cycle, following rr_ptr order. There is no starvation: every valid requester is granted within NUM_REQ*MAX_BURST cycles.
- Requesters with req_valid=0 are ignored; their req_lock is don't-care.

Optional Feature:
- Macro: RF_WR_X0_DROP_EN.
- Defined: a transfer with addr == 0 completes normally (ready, rr_ptr update, lock and burst accounting) but produces WE=0 in the following cycle. A3/WD3 hold their previous values, so x0 is never written.
- Not defined: an addr==0 transfer is forwarded like any other, with WE=1 and A3=0. Protecting x0 is then left to Reg_File or the software.

Test Plan:
- Reset: rst=0 with all req_valid=1 -> req_ready=0, WE=0, A3=0, WD3=0. Release rst; the first grant goes to requester 0.
- Round-robin: NUM_REQ=2, both valid continuously, lock=0, addr0=5/data0=0xAAAA0000, addr1=6/data1=0x0000BBBB -> grants alternate 0,1,0,1. WE=1 every cycle from the second edge, with A3 alternating 5,6.
- Lock and forced release: MAX_BURST=4, requester 1 valid with lock=1 for 6 cycles, requester 0 valid throughout -> four consecutive grants to 1 with locked=1 and lock_owner=1. Requester 0 is then granted, and requester 1 resumes afterwards.
- Early release: lock holder deasserts valid in the cycle after its second transfer -> locked falls at that edge, no grant that cycle, and the next cycle follows ARB order with rr_ptr=owner+1.
- Mid-burst reset: rst=0 asynchronously while locked with WE=1 -> WE=0 and locked=0 before the next clk edge; Reg_File content at addr A3 is unchanged.
- x0 write (RF_WR_X0_DROP_EN defined / undefined): request addr=0, data=0xDEADBEEF -> ready=1 in both builds. The next cycle gives WE=0 when defined, and WE=1 with A3=0 when undefined.
